// File: rtl/rx_pkg.sv
// Shared definitions for the NanEye RX path: capture FSM states and default frame geometry.
package rx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ARM      = 3'd1,
    ST_WAIT_SOF = 3'd2,
    ST_CAPTURE  = 3'd3,
    ST_DONE     = 3'd4
  } rx_state_e;

  localparam int unsigned C_ROWS_DEF = 250;
  localparam int unsigned C_COLS_DEF = 250;
  localparam int unsigned C_PIX_DEF  = C_ROWS_DEF * C_COLS_DEF;

  // States in which the deserializer is armed and the link watchdog runs.
  function automatic logic is_framing(rx_state_e s);
    return (s == ST_WAIT_SOF) || (s == ST_CAPTURE);
  endfunction

endpackage

// File: rtl/rx_watchdog.sv
// Stall watchdog: counts enabled cycles since the last clear and flags when the limit is reached.
module rx_watchdog #(
  parameter int unsigned      TMO_W = 24,
  parameter logic [TMO_W-1:0] C_TMO = 24'd3000000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  logic [TMO_W-1:0] cnt_q, cnt_d;
  logic             expired_q;

  // Count holds at the limit so the expire flag stays asserted until cleared.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != C_TMO)) begin
      cnt_d = cnt_q + TMO_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q     <= '0;
      expired_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      expired_q <= (cnt_d == C_TMO);
    end
  end

  assign expired_o = expired_q;

endmodule

// File: rtl/rx_frame_capture_ctrl.sv
// NanEye RX capture sequencer: arms the deserializer, writes pixels into a ping-pong
// frame buffer and hands completed banks to a reader via READY/ACK.
module rx_frame_capture_ctrl
  import rx_pkg::*;
#(
  parameter int unsigned      C_ROWS    = C_ROWS_DEF,
  parameter int unsigned      C_COLS    = C_COLS_DEF,
  parameter int unsigned      ADDR_W    = 16,
  parameter int unsigned      C_ARM_CYC = 4,
  parameter int unsigned      TMO_W     = 24,
  parameter logic [TMO_W-1:0] C_TMO     = 24'd3000000
) (
  input  logic              SCLOCK,
  input  logic              RESET,
  input  logic              CAP_START,
  input  logic              CAP_CONT,
  input  logic              CAP_ABORT,
  input  logic              ERR_CLR,
  output logic              FRAME_SYNC_START,
  input  logic              DEC_RSYNC,
  input  logic [7:0]        PAR_DATA,
  input  logic              PAR_DATA_EN,
  output logic              WR_EN,
  output logic [ADDR_W:0]   WR_ADDR,
  output logic [7:0]        WR_DATA,
  output logic              FRAME_READY,
  output logic              RD_BANK,
  input  logic              FRAME_ACK,
  output logic              BUSY,
  output logic              ERR_TIMEOUT,
  output logic              ERR_COUNT,
  output logic              ERR_DROP,
  output logic [15:0]       FRAME_CNT
);

  localparam int unsigned C_PIX = C_ROWS * C_COLS;
  localparam int unsigned PIX_W = ADDR_W + 1;
  localparam int unsigned ARM_W = (C_ARM_CYC > 1) ? $clog2(C_ARM_CYC) : 1;

  rx_state_e          state_q, state_d;
  logic [ARM_W-1:0]   arm_cnt_q, arm_cnt_d;
  logic [PIX_W-1:0]   pix_cnt_q, pix_cnt_d;
  logic               wr_bank_q, wr_bank_d;
  logic               wr_en_q, wr_en_d;
  logic [ADDR_W:0]    wr_addr_q, wr_addr_d;
  logic [7:0]         wr_data_q, wr_data_d;
  logic               ready_q, ready_d;
  logic               rd_bank_q, rd_bank_d;
  logic [15:0]        frame_cnt_q, frame_cnt_d;
  logic               err_tmo_q, err_tmo_d;
  logic               err_cnt_q, err_cnt_d;
  logic               err_drop_q, err_drop_d;
  logic               fss_q, busy_q;
  logic               wd_clr, wd_en, wd_expired;

  rx_watchdog #(
    .TMO_W (TMO_W),
    .C_TMO (C_TMO)
  ) u_wdog (
    .clk_i     (SCLOCK),
    .rst_i     (RESET),
    .clr_i     (wd_clr),
    .en_i      (wd_en),
    .expired_o (wd_expired)
  );

  always_comb begin
    state_d     = state_q;
    arm_cnt_d   = arm_cnt_q;
    pix_cnt_d   = pix_cnt_q;
    wr_bank_d   = wr_bank_q;
    wr_en_d     = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    ready_d     = ready_q;
    rd_bank_d   = rd_bank_q;
    frame_cnt_d = frame_cnt_q;
    err_tmo_d   = err_tmo_q  & ~ERR_CLR;
    err_cnt_d   = err_cnt_q  & ~ERR_CLR;
    err_drop_d  = err_drop_q & ~ERR_CLR;

    // ACK is applied before any publish in the same cycle.
    if (FRAME_ACK && ready_q) begin
      ready_d = 1'b0;
    end

    if (CAP_ABORT && (state_q != ST_IDLE)) begin
      state_d = ST_IDLE;
    end else if (wd_expired && is_framing(state_q)) begin
      err_tmo_d = 1'b1;
      state_d   = CAP_CONT ? ST_ARM : ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (CAP_START) state_d = ST_ARM;
        end
        ST_ARM: begin
          if (arm_cnt_q == ARM_W'(C_ARM_CYC - 1)) begin
            state_d = ST_WAIT_SOF;
          end else begin
            arm_cnt_d = arm_cnt_q + ARM_W'(1);
          end
        end
        ST_WAIT_SOF: begin
          pix_cnt_d = '0;
          if (!DEC_RSYNC) state_d = ST_CAPTURE;
        end
        ST_CAPTURE: begin
          if (PAR_DATA_EN) begin
            if (pix_cnt_q < PIX_W'(C_PIX)) begin
              wr_en_d   = 1'b1;
              wr_addr_d = {wr_bank_q, pix_cnt_q[ADDR_W-1:0]};
              wr_data_d = PAR_DATA;
            end
            if (pix_cnt_q != '1) pix_cnt_d = pix_cnt_q + PIX_W'(1);
          end
          if (DEC_RSYNC) state_d = ST_DONE;
        end
        ST_DONE: begin
          if (pix_cnt_q != PIX_W'(C_PIX)) begin
            err_cnt_d = 1'b1;
          end else if (ready_d) begin
            // Reader still owns the other bank: keep writing into the current one.
            err_drop_d = 1'b1;
          end else begin
            rd_bank_d   = wr_bank_q;
            ready_d     = 1'b1;
            wr_bank_d   = ~wr_bank_q;
            frame_cnt_d = frame_cnt_q + 16'd1;
          end
          state_d = CAP_CONT ? ST_ARM : ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end

    if ((state_d == ST_ARM) && (state_q != ST_ARM)) begin
      arm_cnt_d = '0;
    end

    wd_clr = ((state_d == ST_WAIT_SOF) && (state_q != ST_WAIT_SOF)) ||
             ((state_q == ST_CAPTURE) && PAR_DATA_EN);
    wd_en  = is_framing(state_q);
  end

  always_ff @(posedge SCLOCK) begin
    if (RESET) begin
      state_q     <= ST_IDLE;
      arm_cnt_q   <= '0;
      pix_cnt_q   <= '0;
      wr_bank_q   <= 1'b0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      ready_q     <= 1'b0;
      rd_bank_q   <= 1'b0;
      frame_cnt_q <= '0;
      err_tmo_q   <= 1'b0;
      err_cnt_q   <= 1'b0;
      err_drop_q  <= 1'b0;
      fss_q       <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      arm_cnt_q   <= arm_cnt_d;
      pix_cnt_q   <= pix_cnt_d;
      wr_bank_q   <= wr_bank_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      ready_q     <= ready_d;
      rd_bank_q   <= rd_bank_d;
      frame_cnt_q <= frame_cnt_d;
      err_tmo_q   <= err_tmo_d;
      err_cnt_q   <= err_cnt_d;
      err_drop_q  <= err_drop_d;
      fss_q       <= is_framing(state_d);
      busy_q      <= (state_d != ST_IDLE);
    end
  end

  assign FRAME_SYNC_START = fss_q;
  assign WR_EN            = wr_en_q;
  assign WR_ADDR          = wr_addr_q;
  assign WR_DATA          = wr_data_q;
  assign FRAME_READY      = ready_q;
  assign RD_BANK          = rd_bank_q;
  assign BUSY             = busy_q;
  assign ERR_TIMEOUT      = err_tmo_q;
  assign ERR_COUNT        = err_cnt_q;
  assign ERR_DROP         = err_drop_q;
  assign FRAME_CNT        = frame_cnt_q;

endmodule

// File: tb/tb_rx_frame_capture_ctrl.sv
// Randomized bench for rx_frame_capture_ctrl with a 4x4 frame and a frame-level reference model.
module tb_rx_frame_capture_ctrl;

  localparam int unsigned NPIX = 16;
  localparam int unsigned TMO  = 100;

  logic        SCLOCK = 1'b0;
  logic        RESET = 1'b1, CAP_START = 1'b0, CAP_CONT = 1'b0, CAP_ABORT = 1'b0;
  logic        ERR_CLR = 1'b0, DEC_RSYNC = 1'b1, PAR_DATA_EN = 1'b0, FRAME_ACK = 1'b0;
  logic [7:0]  PAR_DATA = 8'h00;
  logic        FRAME_SYNC_START, WR_EN, FRAME_READY, RD_BANK, BUSY;
  logic        ERR_TIMEOUT, ERR_COUNT, ERR_DROP;
  logic [4:0]  WR_ADDR;
  logic [7:0]  WR_DATA;
  logic [15:0] FRAME_CNT;

  int checks = 0;
  int errors = 0;

  // Frame-level model of the buffer/handshake state.
  bit          m_wr_bank, m_ready, m_rd_bank, m_err_cnt, m_err_drop;
  logic [15:0] m_fcnt;
  logic [12:0] exp_q[$];
  logic [12:0] got_q[$];

  rx_frame_capture_ctrl #(
    .C_ROWS(4), .C_COLS(4), .ADDR_W(4), .C_ARM_CYC(4), .TMO_W(24), .C_TMO(24'd100)
  ) dut (
    .SCLOCK(SCLOCK), .RESET(RESET), .CAP_START(CAP_START), .CAP_CONT(CAP_CONT),
    .CAP_ABORT(CAP_ABORT), .ERR_CLR(ERR_CLR), .FRAME_SYNC_START(FRAME_SYNC_START),
    .DEC_RSYNC(DEC_RSYNC), .PAR_DATA(PAR_DATA), .PAR_DATA_EN(PAR_DATA_EN),
    .WR_EN(WR_EN), .WR_ADDR(WR_ADDR), .WR_DATA(WR_DATA), .FRAME_READY(FRAME_READY),
    .RD_BANK(RD_BANK), .FRAME_ACK(FRAME_ACK), .BUSY(BUSY), .ERR_TIMEOUT(ERR_TIMEOUT),
    .ERR_COUNT(ERR_COUNT), .ERR_DROP(ERR_DROP), .FRAME_CNT(FRAME_CNT)
  );

  always #5 SCLOCK = ~SCLOCK;

  always @(negedge SCLOCK) begin
    if (WR_EN === 1'b1) got_q.push_back({WR_ADDR, WR_DATA});
  end

  task automatic apply_reset();
    RESET = 1'b1; CAP_START = 1'b0; CAP_CONT = 1'b0; CAP_ABORT = 1'b0; ERR_CLR = 1'b0;
    DEC_RSYNC = 1'b1; PAR_DATA_EN = 1'b0; FRAME_ACK = 1'b0;
    repeat (3) @(negedge SCLOCK);
    RESET = 1'b0;
    m_wr_bank = 0; m_ready = 0; m_rd_bank = 0; m_err_cnt = 0; m_err_drop = 0; m_fcnt = 16'd0;
    exp_q.delete(); got_q.delete();
  endtask

  task automatic pulse_start();
    CAP_START = 1'b1; @(negedge SCLOCK); CAP_START = 1'b0;
  endtask

  task automatic pulse_abort();
    CAP_ABORT = 1'b1; @(negedge SCLOCK); CAP_ABORT = 1'b0;
  endtask

  task automatic pulse_ack();
    FRAME_ACK = 1'b1; @(negedge SCLOCK); FRAME_ACK = 1'b0;
    m_ready = 0;
  endtask

  task automatic wait_fss();
    int n = 0;
    while (FRAME_SYNC_START !== 1'b1 && n < 64) begin
      @(negedge SCLOCK); n++;
    end
    checks++;
    if (FRAME_SYNC_START !== 1'b1) begin
      errors++; $display("FAIL arm_timeout FRAME_SYNC_START got %0b exp 1", FRAME_SYNC_START);
    end
  endtask

  // Drives one frame of npix pixels with random gaps; updates the model at frame end.
  task automatic drive_frame(input int npix, input bit ack_done);
    wait_fss();
    DEC_RSYNC = 1'b0; @(negedge SCLOCK);
    for (int i = 0; i < npix; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge SCLOCK);
      PAR_DATA = 8'($urandom); PAR_DATA_EN = 1'b1;
      if (i < NPIX) exp_q.push_back({m_wr_bank, 4'(i), PAR_DATA});
      @(negedge SCLOCK); PAR_DATA_EN = 1'b0;
    end
    DEC_RSYNC = 1'b1; @(negedge SCLOCK);
    FRAME_ACK = ack_done; @(negedge SCLOCK); FRAME_ACK = 1'b0;
    if (ack_done) m_ready = 0;
    if (npix != NPIX) m_err_cnt = 1;
    else if (m_ready) m_err_drop = 1;
    else begin
      m_rd_bank = m_wr_bank; m_ready = 1; m_wr_bank = ~m_wr_bank; m_fcnt = m_fcnt + 16'd1;
    end
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if ({FRAME_SYNC_START, WR_EN, BUSY} !== 3'b000) begin
      errors++; $display("FAIL reset_ctl got %b exp 000", {FRAME_SYNC_START, WR_EN, BUSY});
    end
    checks++;
    if ({WR_ADDR, WR_DATA} !== 13'd0) begin
      errors++; $display("FAIL reset_wr got %h exp 0", {WR_ADDR, WR_DATA});
    end
    checks++;
    if ({FRAME_READY, RD_BANK, ERR_TIMEOUT, ERR_COUNT, ERR_DROP} !== 5'b0) begin
      errors++; $display("FAIL reset_flags got %b exp 00000",
                         {FRAME_READY, RD_BANK, ERR_TIMEOUT, ERR_COUNT, ERR_DROP});
    end
    checks++;
    if (FRAME_CNT !== 16'd0) begin
      errors++; $display("FAIL reset_fcnt got %0d exp 0", FRAME_CNT);
    end
  endtask

  task automatic test_single_frame();
    apply_reset();
    PAR_DATA_EN = 1'b1; @(negedge SCLOCK); PAR_DATA_EN = 1'b0; @(negedge SCLOCK);
    checks++;
    if (got_q.size() != 0) begin
      errors++; $display("FAIL idle_pixel writes got %0d exp 0", got_q.size());
    end
    pulse_start();
    checks++;
    if (BUSY !== 1'b1) begin errors++; $display("FAIL single_busy got %0b exp 1", BUSY); end
    drive_frame(NPIX, 1'b0);
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++; $display("FAIL single_wr_count got %0d exp %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL single_wr[%0d] got %h exp %h", i, got_q[i], exp_q[i]);
      end
    end
    checks++;
    if ({FRAME_READY, RD_BANK} !== {m_ready, m_rd_bank}) begin
      errors++; $display("FAIL single_ready_bank got %b exp %b", {FRAME_READY, RD_BANK}, {m_ready, m_rd_bank});
    end
    checks++;
    if (FRAME_CNT !== m_fcnt) begin errors++; $display("FAIL single_fcnt got %0d exp %0d", FRAME_CNT, m_fcnt); end
    checks++;
    if ({BUSY, FRAME_SYNC_START} !== 2'b00) begin
      errors++; $display("FAIL single_idle got %b exp 00", {BUSY, FRAME_SYNC_START});
    end
    pulse_ack();
    checks++;
    if (FRAME_READY !== 1'b0) begin errors++; $display("FAIL single_ack got %0b exp 0", FRAME_READY); end
  endtask

  task automatic test_continuous();
    apply_reset();
    CAP_CONT = 1'b1;
    pulse_start();
    for (int f = 0; f < 3; f++) begin
      exp_q.delete(); got_q.delete();
      drive_frame(NPIX, 1'b0);
      checks++;
      if (got_q.size() != exp_q.size()) begin
        errors++; $display("FAIL cont%0d_wr_count got %0d exp %0d", f, got_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
        checks++;
        if (got_q[i] !== exp_q[i]) begin
          errors++; $display("FAIL cont%0d_wr[%0d] got %h exp %h", f, i, got_q[i], exp_q[i]);
        end
      end
      checks++;
      if ({FRAME_READY, RD_BANK, BUSY} !== {m_ready, m_rd_bank, 1'b1}) begin
        errors++; $display("FAIL cont%0d_ready_bank_busy got %b exp %b", f,
                           {FRAME_READY, RD_BANK, BUSY}, {m_ready, m_rd_bank, 1'b1});
      end
      pulse_ack();
    end
    checks++;
    if (FRAME_CNT !== m_fcnt) begin errors++; $display("FAIL cont_fcnt got %0d exp %0d", FRAME_CNT, m_fcnt); end
    CAP_CONT = 1'b0;
    pulse_abort();
  endtask

  task automatic test_drop();
    apply_reset();
    CAP_CONT = 1'b1;
    pulse_start();
    drive_frame(NPIX, 1'b0);
    drive_frame(NPIX, 1'b0);
    checks++;
    if ({ERR_DROP, FRAME_READY, RD_BANK} !== {m_err_drop, m_ready, m_rd_bank}) begin
      errors++; $display("FAIL drop_flags got %b exp %b", {ERR_DROP, FRAME_READY, RD_BANK},
                         {m_err_drop, m_ready, m_rd_bank});
    end
    checks++;
    if (FRAME_CNT !== m_fcnt) begin errors++; $display("FAIL drop_fcnt got %0d exp %0d", FRAME_CNT, m_fcnt); end
    exp_q.delete(); got_q.delete();
    drive_frame(NPIX, 1'b0);
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++; $display("FAIL drop3_wr_count got %0d exp %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL drop3_wr[%0d] got %h exp %h", i, got_q[i], exp_q[i]);
      end
    end
    ERR_CLR = 1'b1; @(negedge SCLOCK); ERR_CLR = 1'b0;
    m_err_drop = 0;
    checks++;
    if (ERR_DROP !== m_err_drop) begin errors++; $display("FAIL drop_clr got %0b exp 0", ERR_DROP); end
    pulse_abort();
  endtask

  task automatic test_ack_at_publish();
    apply_reset();
    CAP_CONT = 1'b1;
    pulse_start();
    drive_frame(NPIX, 1'b0);
    drive_frame(NPIX, 1'b1);
    checks++;
    if ({FRAME_READY, RD_BANK, ERR_DROP} !== {m_ready, m_rd_bank, m_err_drop}) begin
      errors++; $display("FAIL ackpub_flags got %b exp %b", {FRAME_READY, RD_BANK, ERR_DROP},
                         {m_ready, m_rd_bank, m_err_drop});
    end
    checks++;
    if (FRAME_CNT !== m_fcnt) begin errors++; $display("FAIL ackpub_fcnt got %0d exp %0d", FRAME_CNT, m_fcnt); end
    pulse_abort();
  endtask

  task automatic test_bad_count();
    apply_reset();
    CAP_CONT = 1'b1;
    pulse_start();
    for (int f = 0; f < 3; f++) begin
      exp_q.delete(); got_q.delete();
      drive_frame((f == 0) ? NPIX - 1 : (f == 1) ? NPIX + 1 : NPIX, 1'b0);
      checks++;
      if (got_q.size() != exp_q.size()) begin
        errors++; $display("FAIL cnt%0d_wr_count got %0d exp %0d", f, got_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
        checks++;
        if (got_q[i] !== exp_q[i]) begin
          errors++; $display("FAIL cnt%0d_wr[%0d] got %h exp %h", f, i, got_q[i], exp_q[i]);
        end
      end
      checks++;
      if ({ERR_COUNT, FRAME_READY, RD_BANK} !== {m_err_cnt, m_ready, m_rd_bank}) begin
        errors++; $display("FAIL cnt%0d_flags got %b exp %b", f, {ERR_COUNT, FRAME_READY, RD_BANK},
                           {m_err_cnt, m_ready, m_rd_bank});
      end
      checks++;
      if (FRAME_CNT !== m_fcnt) begin errors++; $display("FAIL cnt%0d_fcnt got %0d exp %0d", f, FRAME_CNT, m_fcnt); end
      if (f == 1) begin
        ERR_CLR = 1'b1; @(negedge SCLOCK); ERR_CLR = 1'b0;
        m_err_cnt = 0;
      end
    end
    pulse_abort();
  endtask

  task automatic test_timeout();
    int cyc;
    apply_reset();
    pulse_start();
    wait_fss();
    repeat (TMO) @(negedge SCLOCK);
    checks++;
    if ({ERR_TIMEOUT, FRAME_SYNC_START} !== 2'b01) begin
      errors++; $display("FAIL tmo_early got %b exp 01", {ERR_TIMEOUT, FRAME_SYNC_START});
    end
    @(negedge SCLOCK);
    checks++;
    if ({ERR_TIMEOUT, FRAME_SYNC_START, BUSY, FRAME_READY} !== 4'b1000) begin
      errors++; $display("FAIL tmo_fire got %b exp 1000", {ERR_TIMEOUT, FRAME_SYNC_START, BUSY, FRAME_READY});
    end
    ERR_CLR = 1'b1; @(negedge SCLOCK); ERR_CLR = 1'b0;
    checks++;
    if (ERR_TIMEOUT !== 1'b0) begin errors++; $display("FAIL tmo_clr got %0b exp 0", ERR_TIMEOUT); end
    // Stall in the middle of a frame: timer restarts at the last pixel.
    CAP_CONT = 1'b1;
    pulse_start();
    wait_fss();
    DEC_RSYNC = 1'b0; @(negedge SCLOCK);
    PAR_DATA_EN = 1'b1; repeat (3) @(negedge SCLOCK);
    cyc = 1;
    PAR_DATA_EN = 1'b0;
    while (ERR_TIMEOUT !== 1'b1 && cyc < 300) begin
      @(negedge SCLOCK); cyc++;
    end
    checks++;
    if (cyc != TMO + 2) begin errors++; $display("FAIL tmo_capture_cycles got %0d exp %0d", cyc, TMO + 2); end
    checks++;
    if ({BUSY, FRAME_SYNC_START, FRAME_READY} !== 3'b100) begin
      errors++; $display("FAIL tmo_capture_state got %b exp 100", {BUSY, FRAME_SYNC_START, FRAME_READY});
    end
    DEC_RSYNC = 1'b1;
    pulse_abort();
  endtask

  task automatic test_abort();
    apply_reset();
    pulse_start();
    drive_frame(NPIX, 1'b0);
    exp_q.delete(); got_q.delete();
    pulse_start();
    wait_fss();
    DEC_RSYNC = 1'b0; @(negedge SCLOCK);
    for (int i = 0; i < 8; i++) begin
      PAR_DATA = 8'($urandom); PAR_DATA_EN = 1'b1;
      if (i == 7) CAP_ABORT = 1'b1;
      else exp_q.push_back({m_wr_bank, 4'(i), PAR_DATA});
      @(negedge SCLOCK); CAP_ABORT = 1'b0;
    end
    checks++;
    if ({BUSY, FRAME_SYNC_START, WR_EN} !== 3'b000) begin
      errors++; $display("FAIL abort_state got %b exp 000", {BUSY, FRAME_SYNC_START, WR_EN});
    end
    repeat (3) @(negedge SCLOCK);
    PAR_DATA_EN = 1'b0; DEC_RSYNC = 1'b1;
    @(negedge SCLOCK);
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++; $display("FAIL abort_wr_count got %0d exp %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL abort_wr[%0d] got %h exp %h", i, got_q[i], exp_q[i]);
      end
    end
    checks++;
    if ({FRAME_READY, RD_BANK, FRAME_CNT} !== {m_ready, m_rd_bank, m_fcnt}) begin
      errors++; $display("FAIL abort_handshake got %b/%0d exp %b/%0d", {FRAME_READY, RD_BANK}, FRAME_CNT,
                         {m_ready, m_rd_bank}, m_fcnt);
    end
  endtask

  task automatic test_reset_midframe();
    apply_reset();
    CAP_CONT = 1'b1;
    pulse_start();
    drive_frame(NPIX, 1'b0);
    wait_fss();
    DEC_RSYNC = 1'b0; @(negedge SCLOCK);
    PAR_DATA_EN = 1'b1; repeat (3) @(negedge SCLOCK);
    RESET = 1'b1; @(negedge SCLOCK);
    checks++;
    if ({BUSY, FRAME_SYNC_START, WR_EN, FRAME_READY, RD_BANK} !== 5'b0) begin
      errors++; $display("FAIL midreset_state got %b exp 00000",
                         {BUSY, FRAME_SYNC_START, WR_EN, FRAME_READY, RD_BANK});
    end
    checks++;
    if (FRAME_CNT !== 16'd0) begin errors++; $display("FAIL midreset_fcnt got %0d exp 0", FRAME_CNT); end
    RESET = 1'b0; PAR_DATA_EN = 1'b0; DEC_RSYNC = 1'b1; CAP_CONT = 1'b0;
    repeat (2) @(negedge SCLOCK);
    checks++;
    if (BUSY !== 1'b0) begin errors++; $display("FAIL midreset_idle got %0b exp 0", BUSY); end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_continuous();
    test_drop();
    test_ack_at_publish();
    test_bad_count();
    test_timeout();
    test_abort();
    test_reset_midframe();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout simulation did not complete");
    $fatal(1, "global timeout");
  end

endmodule
